saes_decryptor: RTL

SAES_DECRYPTOR -- requirements
Module: saes_decryptor

---
 rtl/saes_pkg.sv | 40 ++++
 rtl/saes_key_expand.sv | 28 ++
 rtl/saes_decryptor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/saes_pkg.sv
// Shared S-AES definitions: nibble S-boxes, key-schedule round constants,
// FSM state encoding and GF(2^4) multiply (modulus x^4+x+1).
package saes_pkg;

  localparam logic [3:0] SBOX [16] = '{
    4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
    4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
    4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE
  };

  localparam logic [7:0] RCON1 = 8'h80;
  localparam logic [7:0] RCON2 = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEY  = 3'd1,
    ST_R0   = 3'd2,
    ST_R1   = 3'd3,
    ST_R2   = 3'd4,
    ST_DONE = 3'd5
  } saes_state_e;

  // Shift-and-add multiply; an overflowing shift folds back with x+1 (4'h3).
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[3] ? ({sh[2:0], 1'b0} ^ 4'h3) : {sh[2:0], 1'b0};
    end
    return acc;
  endfunction

endpackage

// File: rtl/saes_key_expand.sv
// Combinational S-AES key schedule: K0 -> round keys K1 (w2w3) and K2 (w4w5).
// Shared with the encryptor, so it holds no state.
module saes_key_expand
  import saes_pkg::*;
(
  input  logic [15:0] key,
  output logic [15:0] k1,
  output logic [15:0] k2
);

  logic [7:0] w0, w1, w2, w3, w4, w5;

  // RotNib swaps the two nibbles, SubNib then substitutes each one.
  function automatic logic [7:0] sub_rot(input logic [7:0] w);
    return {SBOX[w[3:0]], SBOX[w[7:4]]};
  endfunction

  assign w0 = key[15:8];
  assign w1 = key[7:0];
  assign w2 = w0 ^ RCON1 ^ sub_rot(w1);
  assign w3 = w2 ^ w1;
  assign w4 = w2 ^ RCON2 ^ sub_rot(w3);
  assign w5 = w4 ^ w3;

  assign k1 = {w2, w3};
  assign k2 = {w4, w5};

endmodule

// File: rtl/saes_decryptor.sv
// Multi-cycle S-AES decryptor with valid/ready handshakes on both sides.
// Optional SAES_DEC_KEY_CACHE_EN reuses the previous round keys when the key repeats.
module saes_decryptor
  import saes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] cipher_text,
  input  logic [15:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] plain_text
);

  saes_state_e fsm_q, fsm_d;
  logic [15:0] ct_q, ct_d;
  logic [15:0] key_q, key_d;
  logic [15:0] k1_q, k1_d;
  logic [15:0] k2_q, k2_d;
  logic [15:0] st_q, st_d;
  logic [15:0] pt_q, pt_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] k1_w, k2_w;
`ifdef SAES_DEC_KEY_CACHE_EN
  logic [15:0] cache_key_q, cache_key_d;
  logic        cache_valid_q, cache_valid_d;
`endif

  saes_key_expand u_key_expand (
    .key (key_q),
    .k1  (k1_w),
    .k2  (k2_w)
  );

  // Nibble 0 is [15:12]; columns are {n0,n1} and {n2,n3}, so row 1 is {n1,n3}.
  function automatic logic [15:0] inv_shift_rows(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  function automatic logic [15:0] inv_sub_nibs(input logic [15:0] s);
    return {INV_SBOX[s[15:12]], INV_SBOX[s[11:8]], INV_SBOX[s[7:4]], INV_SBOX[s[3:0]]};
  endfunction

  function automatic logic [15:0] inv_mix_cols(input logic [15:0] s);
    return {gf_mul(4'h9, s[15:12]) ^ gf_mul(4'h2, s[11:8]),
            gf_mul(4'h2, s[15:12]) ^ gf_mul(4'h9, s[11:8]),
            gf_mul(4'h9, s[7:4])   ^ gf_mul(4'h2, s[3:0]),
            gf_mul(4'h2, s[7:4])   ^ gf_mul(4'h9, s[3:0])};
  endfunction

  always_comb begin
    fsm_d       = fsm_q;
    ct_d        = ct_q;
    key_d       = key_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    st_d        = st_q;
    pt_d        = pt_q;
    out_valid_d = out_valid_q;
`ifdef SAES_DEC_KEY_CACHE_EN
    cache_key_d   = cache_key_q;
    cache_valid_d = cache_valid_q;
`endif
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          ct_d  = cipher_text;
          key_d = key;
          fsm_d = ST_KEY;
`ifdef SAES_DEC_KEY_CACHE_EN
          if (cache_valid_q && (key == cache_key_q)) fsm_d = ST_R0;
`endif
        end
      end
      ST_KEY: begin
        k1_d  = k1_w;
        k2_d  = k2_w;
`ifdef SAES_DEC_KEY_CACHE_EN
        cache_key_d   = key_q;
        cache_valid_d = 1'b1;
`endif
        fsm_d = ST_R0;
      end
      ST_R0: begin
        st_d  = ct_q ^ k2_q;
        fsm_d = ST_R1;
      end
      ST_R1: begin
        st_d  = inv_mix_cols(inv_sub_nibs(inv_shift_rows(st_q)) ^ k1_q);
        fsm_d = ST_R2;
      end
      ST_R2: begin
        st_d  = inv_sub_nibs(inv_shift_rows(st_q)) ^ key_q;
        fsm_d = ST_DONE;
      end
      ST_DONE: begin
        // First DONE cycle loads the output register; it then holds until consumed.
        if (!out_valid_q) begin
          pt_d        = st_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      ct_q        <= '0;
      key_q       <= '0;
      k1_q        <= '0;
      k2_q        <= '0;
      st_q        <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
`ifdef SAES_DEC_KEY_CACHE_EN
      cache_key_q   <= '0;
      cache_valid_q <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      ct_q        <= ct_d;
      key_q       <= key_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      st_q        <= st_d;
      pt_q        <= pt_d;
      out_valid_q <= out_valid_d;
`ifdef SAES_DEC_KEY_CACHE_EN
      cache_key_q   <= cache_key_d;
      cache_valid_q <= cache_valid_d;
`endif
    end
  end

  assign in_ready   = (fsm_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign plain_text = pt_q;

endmodule
